lsu_mem_ctrl: RTL and testbench

Load/store sequencer between the RV32 execute stage and the single-port data memory (byte-enable writes, 1-cycle synchronous read). It accepts one load/store request at a time, generates the byte enables and lane-aligned write data, and returns sign/zero-extended load data. It splits misaligned accesses into two aligned word accesses, or rejects them when splitting is disabled.

---
 rtl/lsu_mem_ctrl.sv | 168 ++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store sequencer between the RV32 execute stage and a
// single-port, byte-enabled data memory with a 1-cycle synchronous read.
// Accepts one request at a time. Misaligned accesses that cross a word are
// split into two aligned word accesses, or rejected when SPLIT_MISALIGNED=0.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/ready     request handshake (ready only in IDLE)
//   req_we              1 = store, 0 = load
//   req_funct3          RV32 funct3 (B, H, W, BU, HU)
//   req_addr/req_wdata  byte address, right-justified store data
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata/rsp_err   extended load data / illegal or rejected access
//   mem_addr/be/we      word address, byte enables, write strobe
//   mem_wdata/mem_rdata lane-aligned write data / read data (1 cycle later)
//
// state | meaning
// IDLE  | ready for a request; memory bus idle
// ACC0  | first (or only) word access
// ACC1  | second word of a split access; word0 read data captured
// CAP   | extract/extend load data, register the response
module lsu_mem_ctrl #(
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, CAP} state_t;

  state_t                state, state_nx;
  logic                  r_we, r_err, r_split;
  logic [2:0]            r_f3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata, buf0;

  // decode of the incoming request, used only at the accept edge
  logic       in_legal, in_split, in_err;
  logic [2:0] in_bytes;

  always_comb begin
    in_legal = 1'b1;
    in_bytes = 3'd1;
    case (req_funct3)
      3'b000, 3'b100: in_bytes = 3'd1;
      3'b001, 3'b101: in_bytes = 3'd2;
      3'b010:         in_bytes = 3'd4;
      default:        in_legal = 1'b0;
    endcase
    in_split = ({1'b0, req_addr[1:0]} + in_bytes) > 3'd4;
    in_err   = !in_legal || (in_split && !SPLIT_MISALIGNED);
  end

  // lane placement of the latched request across two adjacent words
  logic [1:0]            off;
  logic [3:0]            mask;
  logic [7:0]            be64;
  logic [63:0]           wd64;
  logic [ADDR_WIDTH-1:0] word0;

  always_comb begin
    off = r_addr[1:0];
    case (r_f3[1:0])
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    be64  = {4'b0000, mask} << off;
    wd64  = {32'b0, r_wdata} << {off, 3'b000};
    word0 = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  end

  // load data: in CAP mem_rdata holds the last word read; for a split access
  // buf0 holds word0, so r64 is the little-endian concatenation of both words
  logic [63:0] r64;
  logic [31:0] sh, ext;

  always_comb begin
    r64 = r_split ? {mem_rdata, buf0} : {32'b0, mem_rdata};
    sh  = 32'(r64 >> {off, 3'b000});
    case (r_f3)
      3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
      3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
      3'b100:  ext = {24'b0, sh[7:0]};
      3'b101:  ext = {16'b0, sh[15:0]};
      default: ext = sh;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_split   <= 1'b0;
      r_f3      <= 3'b0;
      r_addr    <= '0;
      r_wdata   <= 32'b0;
      buf0      <= 32'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'b0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      rsp_valid <= (state == CAP);
      if (state == IDLE && req_valid) begin
        r_we    <= req_we;
        r_err   <= in_err;
        r_split <= in_split;
        r_f3    <= req_funct3;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (state == ACC1) buf0 <= mem_rdata;
      if (state == CAP) begin
        rsp_rdata <= (r_we || r_err) ? 32'b0 : ext;
        rsp_err   <= r_err;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = in_err ? CAP : ACC0;
      end
      ACC0: begin
        mem_addr  = word0;
        mem_wdata = wd64[31:0];
        mem_we    = r_we;
        mem_be    = be64[3:0];
        state_nx  = r_split ? ACC1 : CAP;
      end
      ACC1: begin
        mem_addr  = word0 + ADDR_WIDTH'(4);
        mem_wdata = wd64[63:32];
        mem_we    = r_we;
        mem_be    = be64[7:4];
        state_nx  = CAP;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, ns_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
  logic        req_ready, rsp_valid, rsp_err, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;

  logic        ns_ready, ns_rsp_valid, ns_rsp_err, ns_mem_we;
  logic [31:0] ns_rsp_rdata, ns_mem_addr, ns_mem_wdata;
  logic [3:0]  ns_mem_be;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SPLIT_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_be(mem_be), .mem_rdata(mem_rdata));

  lsu_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SPLIT_MISALIGNED(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .req_valid(ns_valid), .req_ready(ns_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(ns_rsp_valid), .rsp_rdata(ns_rsp_rdata),
    .rsp_err(ns_rsp_err), .mem_addr(ns_mem_addr), .mem_wdata(ns_mem_wdata),
    .mem_we(ns_mem_we), .mem_be(ns_mem_be), .mem_rdata(32'h0));

  // 16-word memory model; word 0xFFFFFFFC aliases index 15
  logic [31:0] mem [16];
  logic        init_mem = 1'b0;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < 16; k++) mem[k] <= 32'h0;
      mem[15] <= 32'hCD00_0000;
      mem[0]  <= 32'h0000_00AB;
    end else if (mem_we) begin
      mem[mem_addr[5:2]] <= merge(mem[mem_addr[5:2]], mem_wdata, mem_be);
    end
    mem_rdata <= mem[mem_addr[5:2]];
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwe;
  } vec_t;

  vec_t tv[17];

  logic [31:0] acc_addr[4], acc_wd[4];
  logic [3:0]  acc_be[4];
  int          n_acc;

  // entered just after a negedge; returns just after the negedge of the rsp cycle
  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rdata,
                     output logic err, output int lat, output int nwe);
    bit done = 0;
    chk("ready_before_req", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1 req_valid = 1'b0;
    n_acc = 0; nwe = 0; lat = -1; rdata = 32'hx; err = 1'bx;
    for (int c = 1; c <= 12 && !done; c++) begin
      @(negedge clk);
      if (mem_be != 4'b0 && n_acc < 4) begin
        acc_addr[n_acc] = mem_addr; acc_be[n_acc] = mem_be; acc_wd[n_acc] = mem_wdata;
        n_acc++;
      end
      if (mem_we) nwe++;
      if (rsp_valid) begin lat = c; rdata = rsp_rdata; err = rsp_err; done = 1; end
    end
  endtask

  task automatic run_ns(input logic [2:0] f3, input logic [31:0] addr,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int acts);
    bit done = 0;
    ns_valid = 1'b1; req_we = 1'b0; req_funct3 = f3; req_addr = addr; req_wdata = 32'h0;
    @(posedge clk); #1 ns_valid = 1'b0;
    acts = 0; lat = -1; rdata = 32'hx; err = 1'bx;
    for (int c = 1; c <= 12 && !done; c++) begin
      @(negedge clk);
      if (ns_mem_be != 4'b0 || ns_mem_we) acts++;
      if (ns_rsp_valid) begin lat = c; rdata = ns_rsp_rdata; err = ns_rsp_err; done = 1; end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, nwe, cnt;

    tv[0]  = '{1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 3, 1};
    tv[1]  = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 0};
    tv[2]  = '{1'b1, 3'b000, 32'h0000_0013, 32'h0000_0080, 32'h0000_0000, 1'b0, 3, 1};
    tv[3]  = '{1'b0, 3'b000, 32'h0000_0013, 32'h0,         32'hFFFF_FF80, 1'b0, 3, 0};
    tv[4]  = '{1'b0, 3'b100, 32'h0000_0013, 32'h0,         32'h0000_0080, 1'b0, 3, 0};
    tv[5]  = '{1'b1, 3'b001, 32'h0000_0012, 32'h1234_ABCD, 32'h0000_0000, 1'b0, 3, 1};
    tv[6]  = '{1'b0, 3'b101, 32'h0000_0012, 32'h0,         32'h0000_ABCD, 1'b0, 3, 0};
    tv[7]  = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hABCD_BEEF, 1'b0, 3, 0};
    tv[8]  = '{1'b1, 3'b010, 32'h0000_000E, 32'h1122_3344, 32'h0000_0000, 1'b0, 4, 2};
    tv[9]  = '{1'b0, 3'b010, 32'h0000_000E, 32'h0,         32'h1122_3344, 1'b0, 4, 0};
    tv[10] = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hABCD_1122, 1'b0, 3, 0};
    tv[11] = '{1'b0, 3'b000, 32'h0000_0011, 32'h0,         32'h0000_0011, 1'b0, 3, 0};
    tv[12] = '{1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_ABCD, 1'b0, 4, 0};
    tv[13] = '{1'b0, 3'b011, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1, 2, 0};
    tv[14] = '{1'b1, 3'b111, 32'h0000_0010, 32'h0000_00FF, 32'h0000_0000, 1'b1, 2, 0};
    tv[15] = '{1'b0, 3'b001, 32'h0000_0011, 32'h0,         32'hFFFF_CD11, 1'b0, 3, 0};
    tv[16] = '{1'b0, 3'b101, 32'h0000_0013, 32'h0,         32'h0000_00AB, 1'b0, 4, 0};

    init_mem = 1'b1;
    repeat (2) @(posedge clk);
    #1 init_mem = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_we",    {31'b0, mem_we},    32'd0);
    chk("rst_mem_be",    {28'b0, mem_be},    32'd0);
    chk("rst_mem_addr",  mem_addr,  32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      run(tv[i].we, tv[i].f3, tv[i].addr, tv[i].wdata, rd, er, lat, nwe);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(tv[i].lat));
      chk($sformatf("v%0d_rdata", i), rd, tv[i].rdata);
      chk($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, tv[i].err});
      chk($sformatf("v%0d_nwe", i), 32'(nwe), 32'(tv[i].nwe));
      if (tv[i].err) chk($sformatf("v%0d_no_access", i), 32'(n_acc), 32'd0);
      if (i == 0) begin
        chk("sw_addr", acc_addr[0], 32'h10);
        chk("sw_be", {28'b0, acc_be[0]}, 32'hF);
        chk("sw_wdata", acc_wd[0], 32'hDEAD_BEEF);
      end
      if (i == 2) begin
        chk("sb_be", {28'b0, acc_be[0]}, 32'h8);
        chk("sb_wdata_hi", {24'b0, acc_wd[0][31:24]}, 32'h80);
      end
      if (i == 8) begin
        chk("split_w0_addr", acc_addr[0], 32'h0C);
        chk("split_w0_be", {28'b0, acc_be[0]}, 32'hC);
        chk("split_w0_wd", acc_wd[0], 32'h3344_0000);
        chk("split_w1_addr", acc_addr[1], 32'h10);
        chk("split_w1_be", {28'b0, acc_be[1]}, 32'h3);
        chk("split_w1_wd", acc_wd[1], 32'h0000_1122);
      end
      if (i == 12) begin
        chk("wrap_w0_addr", acc_addr[0], 32'hFFFF_FFFC);
        chk("wrap_w1_addr", acc_addr[1], 32'h0000_0000);
        chk("wrap_w0_be", {28'b0, acc_be[0]}, 32'h8);
        chk("wrap_w1_be", {28'b0, acc_be[1]}, 32'h1);
      end
    end

    // split disabled: misaligned word load and illegal funct3 are rejected
    run_ns(3'b010, 32'h2, rd, er, lat, cnt);
    chk("ns_mis_lat", 32'(lat), 32'd2);
    chk("ns_mis_err", {31'b0, er}, 32'd1);
    chk("ns_mis_rdata", rd, 32'h0);
    chk("ns_mis_acts", 32'(cnt), 32'd0);
    run_ns(3'b011, 32'h10, rd, er, lat, cnt);
    chk("ns_f3_lat", 32'(lat), 32'd2);
    chk("ns_f3_err", {31'b0, er}, 32'd1);
    chk("ns_f3_acts", 32'(cnt), 32'd0);

    // reset during ACC1 of a split store to words 0x20/0x24
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h22; req_wdata = 32'hAABB_CCDD;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rstm_acc0_we", {31'b0, mem_we}, 32'd1);
    @(negedge clk);
    chk("rstm_acc1_addr", mem_addr, 32'h24);
    chk("rstm_acc1_be", {28'b0, mem_be}, 32'h3);
    rst = 1'b1;
    #1;
    chk("rstm_ready", {31'b0, req_ready}, 32'd1);
    chk("rstm_we", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rsp_valid || mem_we) cnt++;
    end
    chk("rstm_no_rsp_or_we", 32'(cnt), 32'd0);
    chk("rstm_word0_kept", mem[8], 32'hCCDD_0000);
    chk("rstm_word1_untouched", mem[9], 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
